// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter at the head of the fetch path.
// Provides sequential stepping, stall hold, PC-relative branch, absolute
// jump, and call/return through a small circular return-address stack.
// Optional build macro: PC_ALIGN_CHECK_EN. When defined, redirects whose
// computed address has nonzero bits [1:0] are rejected and align_err pulses.
// When undefined, align_err is tied low and no alignment logic exists.

module pc_unit #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned OFF_W     = 20,
    parameter int unsigned STEP      = 4,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic [OFF_W-1:0] offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  count,
    output logic             pc_valid,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err,
    output logic             align_err
);

    localparam int unsigned SP_W    = $clog2(RAS_DEPTH);
    localparam int unsigned DEPTH_W = $clog2(RAS_DEPTH + 1);

    localparam logic [PC_W-1:0]    STEP_V     = PC_W'(STEP);
    localparam logic [PC_W-1:0]    RESET_V    = PC_W'(RESET_VEC);
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(RAS_DEPTH);

    // Return-address stack: sp points at the next free slot, depth counts
    // live entries. When full, the slot at sp holds the oldest entry, so a
    // push there naturally overwrites it.
    logic [PC_W-1:0]    ras_mem [RAS_DEPTH];
    logic [SP_W-1:0]    sp;
    logic [DEPTH_W-1:0] depth;

    logic [PC_W-1:0] off_pc;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] top_pc;
    logic [PC_W-1:0] next_pc;
    logic            do_push;
    logic            do_pop;
    logic            ras_err_next;

`ifdef PC_ALIGN_CHECK_EN
    logic            redirect;
    logic            align_err_next;
`endif

    // Bring the branch offset to PC width: truncate a wider offset, sign-extend a narrower one.
    generate
        if (OFF_W >= PC_W) begin : g_off_trunc
            assign off_pc = offset[PC_W-1:0];
            if (OFF_W > PC_W) begin : g_off_hi
                logic unused_offset_hi;
                assign unused_offset_hi = ^offset[OFF_W-1:PC_W];
            end
        end else begin : g_off_sext
            assign off_pc = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
        end
    endgenerate

    assign seq_pc    = count + STEP_V;
    assign top_pc    = ras_mem[sp - SP_W'(1)];
    assign ras_full  = (depth == FULL_DEPTH);
    assign ras_empty = (depth == '0);

    // Pick exactly one action per cycle: stall > ret > call > jump > branch > sequential.
    always_comb begin
        next_pc      = seq_pc;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        ras_err_next = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        redirect       = 1'b0;
        align_err_next = 1'b0;
`endif
        if (stall) begin
            next_pc = count;
        end else if (ret) begin
            if (call) begin
                ras_err_next = 1'b1;
            end
            if (!ras_empty) begin
                next_pc = top_pc;
                do_pop  = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                redirect = 1'b1;
`endif
            end else begin
                ras_err_next = 1'b1;
            end
        end else if (call) begin
            next_pc      = target;
            do_push      = 1'b1;
            ras_err_next = ras_full;
`ifdef PC_ALIGN_CHECK_EN
            redirect = 1'b1;
`endif
        end else if (jump) begin
            next_pc = target;
`ifdef PC_ALIGN_CHECK_EN
            redirect = 1'b1;
`endif
        end else if (branch) begin
            next_pc = count + off_pc;
`ifdef PC_ALIGN_CHECK_EN
            redirect = 1'b1;
`endif
        end
`ifdef PC_ALIGN_CHECK_EN
        // A rejected redirect falls back to sequential and leaves the stack alone,
        // so a rejected call cannot overflow; a call+ret conflict still reports.
        if (redirect && (next_pc[1:0] != 2'b00)) begin
            next_pc        = seq_pc;
            do_push        = 1'b0;
            do_pop         = 1'b0;
            align_err_next = 1'b1;
            if (!ret) begin
                ras_err_next = 1'b0;
            end
        end
`endif
    end

    // PC, valid flag, stack pointers and error pulse; reset discards the stack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= RESET_V;
            pc_valid <= 1'b0;
            sp       <= '0;
            depth    <= '0;
            ras_err  <= 1'b0;
        end else begin
            count    <= next_pc;
            pc_valid <= 1'b1;
            ras_err  <= ras_err_next;
            if (do_push) begin
                sp <= sp + SP_W'(1);
                if (!ras_full) begin
                    depth <= depth + DEPTH_W'(1);
                end
            end else if (do_pop) begin
                sp    <= sp - SP_W'(1);
                depth <= depth - DEPTH_W'(1);
            end
        end
    end

    // Stack storage has no reset; depth alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            ras_mem[sp] <= seq_pc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle pulse for each rejected misaligned redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            align_err <= 1'b0;
        end else begin
            align_err <= align_err_next;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter: next generation of the fixed 16-bit PC.
- Adds configurable width and step, stall hold, absolute jump, and call/return via an internal return-address stack (RAS).
- Sits at the head of the fetch path. Drives the instruction-memory address (count) and takes redirect controls from decode/branch logic.

Parameters:
- PC_W, 16, width of count, target and stack entries.
- OFF_W, 20, width of the signed branch offset.
- STEP, 4, sequential increment in bytes.
- RESET_VEC, 0, value loaded into count by reset.
- RAS_DEPTH, 4, number of return-stack entries (power of two, >=2).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
- stall  in  1  1 = hold count and RAS, ignore all redirects.
- branch  in  1  PC-relative redirect: count + offset.
- offset  in  OFF_W  signed two's-complement branch offset.
- jump  in  1  absolute redirect to target.
- call  in  1  push count+STEP onto RAS, redirect to target.
- ret  in  1  pop RAS, redirect to popped address.
- target  in  PC_W  absolute address for jump/call.
- count  out  PC_W  current PC (registered).
- pc_valid  out  1  count is a valid fetch address.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_empty  out  1  RAS holds 0 entries.
- ras_err  out  1  one-cycle pulse on overflow, underflow or call+ret conflict.
- align_err  out  1  one-cycle pulse on rejected misaligned redirect (see Optional Feature).

Behaviour:
- Reset (reset==0 at posedge), overriding all other inputs:
  - count=RESET_VEC, pc_valid=0, RAS emptied (ras_empty=1, ras_full=0).
  - ras_err=0, align_err=0.
  - Reset mid-call/ret discards the stack contents.
- First posedge with reset==1: pc_valid=1, and it stays 1 until the next reset. That edge also performs a normal update.
- Priority per edge, reset==1: stall > ret > call > jump > branch > sequential. Exactly one action per cycle.
- stall=1:
  - count, RAS and pointers unchanged.
  - ras_err=0, align_err=0.
  - Redirects presented during stall are lost; the requester must hold them.
- Sequential: count <= count + STEP.
- branch:
  - count <= count + sext(offset), computed modulo 2^PC_W.
  - OFF_W > PC_W: offset truncated to PC_W bits after sign interpretation.
  - OFF_W < PC_W: offset sign-extended.
- jump: count <= target.
- call:
  - Push (count + STEP) mod 2^PC_W, then count <= target.
  - If full: oldest entry overwritten (circular), depth stays RAS_DEPTH, ras_err pulses.
- ret:
  - Not empty: count <= top entry, depth decrements.
  - Empty: behaves as sequential (count+STEP) and ras_err pulses.
- call and ret both 1 (not stalled): ret executes, call ignored, ras_err pulses.
- Wrap-around:
  - count rolls over silently, e.g. PC_W=16: 0xFFFC + 4 = 0x0000.
  - Not an error.
- RAS flags:
  - Registered, consistent with depth after each edge.
  - full and empty are never both 1.
- Latency: redirect inputs sampled at edge N appear on count after edge N (single-cycle). No pipeline bubble inserted.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: any jump/call/ret/branch whose computed next address has nonzero bits [1:0] is rejected.
  - count <= count + STEP.
  - RAS unchanged: a call does not push; a ret does not pop.
  - align_err pulses for one cycle.
- Undefined:
  - align_err tied 0.
  - Misaligned addresses are loaded unchanged.
  - No alignment logic synthesised.

Test Plan:
- Reset/sequential: hold reset=0 two cycles, release -> count=0x0000, pc_valid=0 during reset; after release count steps 0x0004, 0x0008, 0x000C and pc_valid=1.
- Branch sign/wrap: count=0x0010, branch=1, offset=20'hFFFF0 (-16) -> count=0x0000. count=0xFFFC, sequential -> 0x0000 with no error.
- Call/ret nesting, RAS_DEPTH=4:
  - At count=0x0100, call target=0x2000 -> count=0x2000, ras_empty=0.
  - Then call target=0x3000 -> count=0x3000.
  - ret -> 0x2004; ret -> 0x0104, ras_empty=1.
- Overflow/underflow: 5 calls -> ras_full=1 and ras_err pulse on the 5th; 4 rets return the 4 newest addresses in LIFO order; 5th ret -> count+4, ras_err pulse.
- Stall and priority:
  - stall=1 with ret=1 and branch=1 for 3 cycles -> count and RAS unchanged.
  - Release with call=1, ret=1 -> pop executed, ras_err pulse, no push.
- Alignment, with PC_ALIGN_CHECK_EN: jump target=0x0102 at count=0x0040 -> count=0x0044, align_err=1 one cycle. Without the macro -> count=0x0102, align_err=0.
